systolic_operand_feeder: RTL and testbench

- Upstream feeder for the N×N FP32 systolic multiplier array.
- Buffers matrix A (N×N) and matrix B (N×N), loaded over a single 32-bit valid/ready stream.
- On START, drives the array's left edge (one A element per row) and top edge (one B element per column), one k-index per beat.
- Inserts zero-valued gap cycles between beats to match the PE accumulate-loop latency, then zero-valued drain cycles, then pulses DONE.

---
 rtl/systolic_operand_feeder_pkg.sv | 20 ++
 rtl/systolic_operand_feeder_operand_bank.sv | 42 ++++
 rtl/systolic_operand_feeder.sv | 171 +++++++++++++++++
 tb/tb_systolic_operand_feeder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_operand_feeder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systolic_operand_feeder_pkg: shared constants and FSM encoding      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package systolic_operand_feeder_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_ARMED = 3'd1,
    ST_BEAT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/systolic_operand_feeder_operand_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systolic_operand_feeder_operand_bank: NxN FP32 operand store        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module systolic_operand_feeder_operand_bank
  import systolic_operand_feeder_pkg::*;
#(
  parameter int N        = 4,
  parameter bit ROW_READ = 1'b0
) (
  input  logic                     CLK,
  input  logic                     wr_en_i,
  input  logic [$clog2(N*N)-1:0]   wr_idx_i,
  input  logic [31:0]              wr_data_i,
  input  logic [$clog2(N)-1:0]     k_i,
  output logic [N*32-1:0]          rd_data_o
);

  localparam int IW = $clog2(N*N);

  logic [31:0] mem_q [N*N];

  // Contents deliberately survive reset; every run fully reloads them.
  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_rd
    logic [IW-1:0] rd_idx;
    if (ROW_READ) begin : g_row
      assign rd_idx = IW'(k_i) * IW'(N) + IW'(i);
    end else begin : g_col
      assign rd_idx = IW'(i * N) + IW'(k_i);
    end
    assign rd_data_o[32*i +: 32] = mem_q[rd_idx];
  end

endmodule
`default_nettype wire

// File: rtl/systolic_operand_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systolic_operand_feeder: loads A/B, streams k-beats with gap/drain  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module systolic_operand_feeder
  import systolic_operand_feeder_pkg::*;
#(
  parameter int N     = 4,
  parameter int GAP   = 2,
  parameter int DRAIN = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [31:0]     LOAD_DATA,
  input  logic            LOAD_VALID,
  output logic            LOAD_READY,
  input  logic            START,
  output logic [N*32-1:0] LEFT_OUT,
  output logic [N*32-1:0] TOP_OUT,
  output logic            BEAT,
  output logic            BUSY,
  output logic            DONE
);

  localparam int WORDS = 2 * N * N;
  localparam int LW    = $clog2(WORDS);
  localparam int IW    = $clog2(N * N);
  localparam int KW    = $clog2(N);
  localparam int GW    = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int DW    = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;

  localparam logic [LW-1:0] LAST_WORD  = LW'(WORDS - 1);
  localparam logic [LW-1:0] HALF       = LW'(N * N);
  localparam logic [KW-1:0] K_LAST     = KW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN - 1);

  state_e              state_q, state_d;
  logic [LW-1:0]       load_q, load_d;
  logic [KW-1:0]       k_q, k_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [N*32-1:0]     left_q, left_d, top_q, top_d;
  logic                beat_q, beat_d, busy_q, busy_d, done_q, done_d;

  logic                xfer;
  logic                in_a;
  logic [N*32-1:0]     a_col, b_row;

  assign LOAD_READY = (state_q == ST_LOAD);
  assign xfer       = LOAD_READY & LOAD_VALID;
  assign in_a       = (load_q < HALF);

  // Banks are read with next-state k so the registered outputs line up with the state.
  systolic_operand_feeder_operand_bank #(.N(N), .ROW_READ(1'b0)) u_bank_a (
    .CLK       (CLK),
    .wr_en_i   (xfer & in_a),
    .wr_idx_i  (IW'(load_q)),
    .wr_data_i (LOAD_DATA),
    .k_i       (k_d),
    .rd_data_o (a_col)
  );

  systolic_operand_feeder_operand_bank #(.N(N), .ROW_READ(1'b1)) u_bank_b (
    .CLK       (CLK),
    .wr_en_i   (xfer & ~in_a),
    .wr_idx_i  (IW'(load_q - HALF)),
    .wr_data_i (LOAD_DATA),
    .k_i       (k_d),
    .rd_data_o (b_row)
  );

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    k_d     = k_q;
    gap_d   = gap_q;
    drain_d = drain_q;
    case (state_q)
      ST_LOAD: begin
        if (LOAD_VALID) begin
          if (load_q == LAST_WORD) begin
            load_d  = '0;
            state_d = ST_ARMED;
          end else begin
            load_d = load_q + LW'(1);
          end
        end
      end
      ST_ARMED: begin
        if (START) begin
          state_d = ST_BEAT;
          k_d     = '0;
        end
      end
      ST_BEAT: begin
        if (k_q != K_LAST) begin
          if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end else if (DRAIN > 0) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_BEAT;
          k_d     = k_q + KW'(1);
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      ST_DONE:  state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase

    beat_d = (state_d == ST_BEAT);
    busy_d = beat_d | (state_d == ST_GAP) | (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    left_d = beat_d ? a_col : {N{FP_ZERO}};
    top_d  = beat_d ? b_row : {N{FP_ZERO}};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_LOAD;
      load_q  <= '0;
      k_q     <= '0;
      gap_q   <= '0;
      drain_q <= '0;
      left_q  <= {N{FP_ZERO}};
      top_q   <= {N{FP_ZERO}};
      beat_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      drain_q <= drain_d;
      left_q  <= left_d;
      top_q   <= top_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign LEFT_OUT = left_q;
  assign TOP_OUT  = top_q;
  assign BEAT     = beat_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_operand_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_systolic_operand_feeder: random-load / stream checks, two configs|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_systolic_operand_feeder;

  localparam int N = 4;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [31:0]     LOAD_DATA;
  logic            LOAD_VALID;
  logic            START;
  logic [N*32-1:0] left0, top0, left1, top1;
  logic            rdy0, rdy1, beat0, beat1, busy0, busy1, done0, done1;

  int checks = 0;
  int errors = 0;

  logic [31:0]     a_m [N][N];
  logic [31:0]     b_m [N][N];
  logic [N*32-1:0] left_c1, top_c1;

  always #5 CLK = ~CLK;

  systolic_operand_feeder #(.N(N), .GAP(2), .DRAIN(4)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .LOAD_DATA(LOAD_DATA), .LOAD_VALID(LOAD_VALID),
    .LOAD_READY(rdy0), .START(START), .LEFT_OUT(left0), .TOP_OUT(top0),
    .BEAT(beat0), .BUSY(busy0), .DONE(done0)
  );

  systolic_operand_feeder #(.N(N), .GAP(0), .DRAIN(0)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .LOAD_DATA(LOAD_DATA), .LOAD_VALID(LOAD_VALID),
    .LOAD_READY(rdy1), .START(START), .LEFT_OUT(left1), .TOP_OUT(top1),
    .BEAT(beat1), .BUSY(busy1), .DONE(done1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // FP32 encoding of a small positive integer.
  function automatic logic [31:0] fp_int(input int v);
    int e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((v - (1 << e)) << (23 - e))};
  endfunction

  // Cycle c after the accepting START edge carries beat k when c-1 = k*(g+1).
  function automatic logic [127:0] exp_vec(input int c, input int g, input bit is_top);
    logic [127:0] v = '0;
    int k;
    if (c >= 1 && ((c - 1) % (g + 1)) == 0) begin
      k = (c - 1) / (g + 1);
      if (k < N)
        for (int i = 0; i < N; i++) v[32*i +: 32] = is_top ? b_m[k][i] : a_m[i][k];
    end
    return v;
  endfunction

  task automatic check_dut(input int id, input int c, input int g, input int d,
                           input logic [127:0] l, input logic [127:0] t,
                           input logic be, input logic bu, input logic dn);
    int done_c = 1 + (N - 1) * (g + 1) + 1 + d;
    bit beat_e = ((c - 1) % (g + 1) == 0) && ((c - 1) / (g + 1) < N);
    check($sformatf("d%0d_c%0d_left", id, c), l, exp_vec(c, g, 1'b0));
    check($sformatf("d%0d_c%0d_top", id, c), t, exp_vec(c, g, 1'b1));
    check($sformatf("d%0d_c%0d_beat", id, c), be, beat_e);
    check($sformatf("d%0d_c%0d_busy", id, c), bu, c < done_c);
    check($sformatf("d%0d_c%0d_done", id, c), dn, c == done_c);
  endtask

  task automatic stream(input int ncyc, input bit hold);
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (!hold) START = 1'b0;
      if (c == 1) begin
        left_c1 = left0;
        top_c1  = top0;
      end
      check_dut(0, c, 2, 4, left0, top0, beat0, busy0, done0);
      check_dut(1, c, 0, 0, left1, top1, beat1, busy1, done1);
    end
  endtask

  task automatic load_all(input bit rand_valid, input bit start_at10);
    int sent = 0;
    int cyc = 0;
    bit pulsed = 0;
    logic [31:0] words [2*N*N];
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        words[r*N + c]       = a_m[r][c];
        words[N*N + r*N + c] = b_m[r][c];
      end
    while (sent < 2*N*N && cyc < 1000) begin
      LOAD_VALID = rand_valid ? 1'($urandom_range(0, 1)) : (cyc % 2 == 0);
      LOAD_DATA  = LOAD_VALID ? words[sent] : $urandom;
      if (start_at10) begin
        START = (sent == 10) && !pulsed;
        if (START) pulsed = 1;
      end
      check("ready_load0", rdy0, 1'b1);
      check("ready_load1", rdy1, 1'b1);
      if (LOAD_VALID && rdy0) sent++;
      tick();
      cyc++;
    end
    LOAD_VALID = 1'b0;
    if (start_at10) START = 1'b0;
    check("load_words", sent, 2*N*N);
    check("ready_armed0", rdy0, 1'b0);
    check("ready_armed1", rdy1, 1'b0);
  endtask

  task automatic rand_mats();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = $urandom;
        b_m[r][c] = $urandom;
      end
  endtask

  initial begin
    RST_N = 1'b0; LOAD_VALID = 1'b0; START = 1'b0; LOAD_DATA = '0;
    repeat (2) tick();
    check("rst_left", {left0, left1}, '0);
    check("rst_top", {top0, top1}, '0);
    check("rst_flags", {beat0, busy0, done0, beat1, busy1, done1}, '0);
    check("rst_ready", {rdy0, rdy1}, 2'b11);
    RST_N = 1'b1;
    tick();

    // Known operands, valid toggled every other cycle, START held through DONE.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = fp_int(r*4 + c + 1);
        b_m[r][c] = (r == c) ? 32'h3F80_0000 : 32'h0;
      end
    load_all(1'b0, 1'b0);
    LOAD_VALID = 1'b1; LOAD_DATA = 32'hDEAD_BEEF;
    repeat (3) begin
      tick();
      check("extra_word_ready", rdy0, 1'b0);
      check("extra_word_busy", busy0, 1'b0);
    end
    LOAD_VALID = 1'b0;
    START = 1'b1;
    stream(17, 1'b1);
    check("lit_left_r0", left_c1[31:0], 32'h3F80_0000);
    check("lit_left_r3", left_c1[127:96], 32'h4150_0000);
    check("lit_top_c0", top_c1[31:0], 32'h3F80_0000);
    check("lit_top_rest", top_c1[127:32], '0);
    repeat (5) begin
      tick();
      check("no_restart_ready", rdy0, 1'b1);
      check("no_restart_busy", {busy0, busy1, beat0, beat1}, '0);
    end

    // Reload with START still high: streaming resumes on the edge after ARMED.
    rand_mats();
    load_all(1'b1, 1'b0);
    stream(17, 1'b0);

    // START pulsed mid-load must be ignored.
    rand_mats();
    load_all(1'b0, 1'b1);
    check("armed_left", {left0, left1}, '0);
    check("armed_flags", {beat0, busy0, done0, beat1, busy1, done1}, '0);
    START = 1'b1;
    stream(17, 1'b0);

    // Reset in cycle 5 of streaming.
    rand_mats();
    load_all(1'b1, 1'b0);
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    RST_N = 1'b0;
    #1;
    check("mid_rst_left", {left0, left1}, '0);
    check("mid_rst_top", {top0, top1}, '0);
    check("mid_rst_busy", {busy0, busy1}, '0);
    check("mid_rst_ready", {rdy0, rdy1}, 2'b11);
    check("mid_rst_done", {done0, done1}, '0);
    tick();
    RST_N = 1'b1;
    repeat (16) begin
      tick();
      check("post_rst_done", {done0, done1}, '0);
      check("post_rst_busy", {busy0, busy1}, '0);
    end

    // Recovery after reset.
    rand_mats();
    load_all(1'b1, 1'b0);
    START = 1'b1;
    stream(17, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
